// File: rtl/ufpu_mc.sv
// Multi-context bit-vector filter/policy unit: two-stage valid/ready pipeline with
// per-context round-robin / weighted round-robin state and a Galois LFSR for random pick.
module ufpu_mc #(
    parameter int         BIT_VEC_SIZE     = 8,
    parameter int         BIT_VEC_SIZE_LOG = 3,
    parameter int         VAL_W            = 16,
    parameter int         CTX              = 4,
    parameter int         CTX_LOG          = 2,
    parameter logic [7:0] LFSR_TAPS        = 8'hB8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BIT_VEC_SIZE-1:0]       in,
    input  logic [BIT_VEC_SIZE*VAL_W-1:0] metric,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [2:0]                    opcode,
    input  logic [CTX_LOG-1:0]            ctx,
    input  logic [BIT_VEC_SIZE_LOG-1:0]   id,
    input  logic [VAL_W-1:0]              val,
    input  logic [2:0]                    pred_op,
    output logic [BIT_VEC_SIZE-1:0]       out,
    output logic                          valid_out,
    input  logic                          ready_out
);
    localparam int N = BIT_VEC_SIZE;
    localparam int L = BIT_VEC_SIZE_LOG;
    // The top L bits of the tap constant form the polynomial for an L-bit register.
    localparam logic [L-1:0] TAPS = LFSR_TAPS[7 -: L];

    logic                 adv;
    logic                 s1_valid_q, s1_valid_d;
    logic [N-1:0]         s1_in_q, s1_in_d;
    logic [N*VAL_W-1:0]   s1_metric_q, s1_metric_d;
    logic [2:0]           s1_op_q, s1_op_d;
    logic [CTX_LOG-1:0]   s1_ctx_q, s1_ctx_d;
    logic [L-1:0]         s1_id_q, s1_id_d;
    logic [VAL_W-1:0]     s1_val_q, s1_val_d;
    logic [2:0]           s1_pred_q, s1_pred_d;
    logic [N-1:0]         out_q, out_d;
    logic                 valid_out_q, valid_out_d;
    logic [L-1:0]         last_id_q [CTX];
    logic [L-1:0]         last_id_d [CTX];
    logic [VAL_W-1:0]     w_q [CTX];
    logic [VAL_W-1:0]     w_d [CTX];
    logic [L-1:0]         lfsr_q, lfsr_d;

    logic [L-1:0]         cur_last;
    logic [VAL_W-1:0]     cur_w;
    logic [VAL_W-1:0]     m_last;
    logic [VAL_W-1:0]     wt;
    logic [L-1:0]         sel;
    logic [L-1:0]         lfsr_step;

    // First set bit of v at or after s, wrapping: rotate right by s, then priority-encode.
    function automatic logic [L-1:0] scan_next(input logic [N-1:0] v, input logic [L-1:0] s);
        logic [N-1:0] rot;
        logic [L-1:0] p;
        rot = N'({v, v} >> s);
        p   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) p = L'(i);
        end
        return s + p;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [L-1:0] i);
        return N'(1) << i;
    endfunction

    function automatic logic pred_hit(input logic [VAL_W-1:0] m, input logic [VAL_W-1:0] v,
                                      input logic [2:0] op);
        case (op)
            3'b000:  return m < v;
            3'b001:  return m > v;
            3'b010:  return m <= v;
            3'b011:  return m >= v;
            3'b100:  return m == v;
            3'b101:  return m != v;
            default: return 1'b0;
        endcase
    endfunction

    assign adv       = !valid_out_q | ready_out;
    assign ready_in  = adv;
    assign out       = out_q;
    assign valid_out = valid_out_q;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_in_d     = s1_in_q;
        s1_metric_d = s1_metric_q;
        s1_op_d     = s1_op_q;
        s1_ctx_d    = s1_ctx_q;
        s1_id_d     = s1_id_q;
        s1_val_d    = s1_val_q;
        s1_pred_d   = s1_pred_q;
        out_d       = out_q;
        valid_out_d = valid_out_q;
        last_id_d   = last_id_q;
        w_d         = w_q;
        lfsr_d      = lfsr_q;
        sel         = '0;

        cur_last  = last_id_q[s1_ctx_q];
        cur_w     = w_q[s1_ctx_q];
        m_last    = s1_metric_q[cur_last*VAL_W +: VAL_W];
        wt        = (m_last == '0) ? VAL_W'(1) : m_last;
        lfsr_step = {1'b0, lfsr_q[L-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

        if (adv) begin
            s1_valid_d  = valid_in;
            s1_in_d     = in;
            s1_metric_d = metric;
            s1_op_d     = opcode;
            s1_ctx_d    = ctx;
            s1_id_d     = id;
            s1_val_d    = val;
            s1_pred_d   = pred_op;
            valid_out_d = s1_valid_q;
            out_d       = '0;
            if (s1_valid_q) begin
                unique case (s1_op_q)
                    3'b000: out_d = s1_in_q;
                    3'b001: out_d = s1_in_q & onehot(s1_id_q);
                    3'b010: begin
                        for (int i = 0; i < N; i++) begin
                            out_d[i] = s1_in_q[i] &
                                pred_hit(s1_metric_q[i*VAL_W +: VAL_W], s1_val_q, s1_pred_q);
                        end
                    end
                    3'b011: out_d = s1_in_q & (~s1_in_q + N'(1));
                    3'b100: begin
                        if (|s1_in_q) begin
                            out_d  = onehot(scan_next(s1_in_q, lfsr_q));
                            lfsr_d = lfsr_step;
                        end
                    end
                    3'b101: begin
                        if (|s1_in_q) begin
                            if (s1_in_q[cur_last] && (cur_w < wt)) begin
                                out_d = onehot(cur_last);
                                w_d[s1_ctx_q] = (cur_w == '1) ? cur_w : cur_w + VAL_W'(1);
                            end else begin
                                sel = scan_next(s1_in_q, cur_last + L'(1));
                                out_d = onehot(sel);
                                last_id_d[s1_ctx_q] = sel;
                                w_d[s1_ctx_q] = VAL_W'(1);
                            end
                        end
                    end
                    3'b110: begin
                        if (|s1_in_q) begin
                            sel = scan_next(s1_in_q, cur_last + L'(1));
                            out_d = onehot(sel);
                            last_id_d[s1_ctx_q] = sel;
                        end
                    end
                    3'b111: out_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_q <= 1'b0;
            out_q       <= '0;
            s1_valid_q  <= 1'b0;
            lfsr_q      <= L'(1);
            for (int c = 0; c < CTX; c++) begin
                last_id_q[c] <= '0;
                w_q[c]       <= '0;
            end
        end else begin
            valid_out_q <= valid_out_d;
            out_q       <= out_d;
            s1_valid_q  <= s1_valid_d;
            lfsr_q      <= lfsr_d;
            last_id_q   <= last_id_d;
            w_q         <= w_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_in_q     <= s1_in_d;
        s1_metric_q <= s1_metric_d;
        s1_op_q     <= s1_op_d;
        s1_ctx_q    <= s1_ctx_d;
        s1_id_q     <= s1_id_d;
        s1_val_q    <= s1_val_d;
        s1_pred_q   <= s1_pred_d;
    end
endmodule

// File: doc/ufpu_mc.md
Name: ufpu_mc

Overview:
- Multi-context, parametrised bit-vector filter/policy unit for the scheduler datapath.
- Takes a candidate bit vector plus per-bit metric values and emits a filtered or one-hot selected vector.
- Keeps independent round-robin and weighted-round-robin state for CTX contexts.
- Adds valid/ready backpressure, a second round-robin mode and a configurable-width LFSR.

Parameters:
BIT_VEC_SIZE, 8, candidate vector width N (power of two, >=4)
BIT_VEC_SIZE_LOG, 3, log2(N)
VAL_W, 16, metric/weight value width
CTX, 4, number of independent scheduling contexts
CTX_LOG, 2, log2(CTX)
LFSR_TAPS, 8'hB8, Galois feedback taps, BIT_VEC_SIZE_LOG bits used

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in  in  N  candidate bit vector
metric  in  N*VAL_W  per-bit metric; bit i at [i*VAL_W +: VAL_W]
valid_in  in  1  request valid
ready_in  out  1  unit accepts request this cycle
opcode  in  3  operation select
ctx  in  CTX_LOG  context for opcodes 101/110
id  in  BIT_VEC_SIZE_LOG  bit index for opcode 001
val  in  VAL_W  predicate threshold
pred_op  in  3  predicate select
out  out  N  result vector
valid_out  out  1  result valid
ready_out  in  1  downstream accepts result

Behaviour:
- Reset (synchronous, active-high):
  - valid_out=0, out=0, stage-1 valid=0.
  - For all contexts: last_id=0, w=0.
  - LFSR=1.
- Pipeline control:
  - Two stages; adv = !valid_out | ready_out; ready_in = adv.
  - Request accepted when valid_in & ready_in. Stage 1 registers in, metric, opcode, ctx, id, val, pred_op.
  - Stage 2 computes and registers out/valid_out on adv. Latency is 2 cycles from accept to valid_out under no backpressure.
  - One result per cycle sustained throughput.
  - While !adv: both stages hold, no state updates, out stable.
- Context state is read and written only in stage 2 on adv, so back-to-back requests on the same ctx see the updated state.
- Cyclic scan next(v,s): first set bit of v at s, s+1, ..., wrapping mod N. Uses a rotate plus priority encoder. Result is invalid if v==0.
- Opcodes (stage 2):
  - 000: out=in.
  - 001: out=in & onehot(id).
  - 010: out[i]=in[i] & P(metric[i],val), unsigned compare.
    - pred_op 000 <, 001 >, 010 <=, 011 >=, 100 ==, 101 !=, 11x false.
  - 011: out=onehot(lowest set bit of in); out=0 if in==0.
  - 100 (random):
    - r = LFSR value; out=onehot(next(in,r)).
    - LFSR advances one Galois step per accepted 100 op (only in stage 2 on adv). Period 2^L-1; value 0 never occurs.
  - 101 (weighted RR, weight = metric):
    - L=last_id[ctx], W=w[ctx].
    - If in[L] & W < metric[L]: out=onehot(L), w[ctx]=W+1.
    - Else: s=next(in,L+1 mod N); out=onehot(s), last_id[ctx]=s, w[ctx]=1.
    - A weight of 0 is treated as 1.
  - 110 (plain RR): s=next(in,last_id[ctx]+1 mod N); out=onehot(s), last_id[ctx]=s.
  - 111: out=0, valid_out=1.
- Boundaries:
  - in==0 for 011/100/101/110: out=0, valid_out=1, no state change.
  - w saturates at 2^VAL_W-1.
  - If the only set bit is last_id and its weight is exhausted, that same bit is reselected and w=1.
  - Reset mid-operation discards both stages; no result is emitted for in-flight requests.
  - Unused contexts are untouched.

Test Plan:
- Reset, then op 000 in=8'hA5 with ready_out=1 -> valid_out asserted exactly 2 cycles after accept, out=8'hA5; op 001 id=2 in=8'hFF -> out=8'h04.
- Op 010 metric={70,60,50,40,30,20,10,0} (bits 7..0), in=8'hFF, val=35, pred_op=001 -> out=8'hF0; same with pred_op=100, val=40 -> out=8'h10.
- Op 101 ctx=0, in=8'h0A, metric[1]=2, metric[3]=1, six back-to-back requests -> outs 02,02,08,02,02,08; ctx=1 interleaved with in=8'h01 -> always 01, ctx0 sequence unaffected.
- Op 110 ctx=2, in=8'h81 repeated, then in=8'h00 -> 80,01,80 then 00 with last_id[2]=7 retained; next in=8'h81 -> 01.
- Backpressure: hold ready_out=0 after two accepts -> ready_in=0, out frozen, a third valid_in not accepted; release -> results delivered in order with none lost or duplicated.
- Op 100 after reset, in=8'h01 -> out=01 (fallback scan from r=1 wraps to bit 0); in=8'hFF for 7 requests -> each out equals onehot(LFSR sequence 1,...) per LFSR_TAPS; reset asserted mid-stream -> valid_out=0 next cycle.
